superscalar_pipe_reg: RTL and testbench
=======================================

Name: superscalar_pipe_reg

Overview:
- Parametrised pipeline register for the superscalar datapath. Carries a bundle of LANES instructions between stages, e.g. ID to RF or RF to EX.
- Replaces per-stage hard-wired registers with one block. Adds a valid/ready handshake, a 2-entry skid buffer, a global flush and per-lane squash of the head bundle.
- Invalid or flushed lanes always present the NOP opcode downstream.

Parameters:
- LANES, 2, issue width: number of instruction lanes per bundle.
- PAYLOAD_W, 64, per-lane payload bits (PC, PC+2, control, regs, immediates), excluding the opcode.
- OPC_W, 4, opcode width per lane.
- NOP_OPC, 4'b1111, opcode driven on invalid, flushed or reset lanes.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- in_valid, in, LANES, per-lane valid of the incoming bundle.
- in_opcode, in, LANES*OPC_W, lane i at [i*OPC_W +: OPC_W].
- in_payload, in, LANES*PAYLOAD_W, lane i at [i*PAYLOAD_W +: PAYLOAD_W].
- in_ready, out, 1, stage can accept a bundle this cycle.
- out_valid, out, LANES, per-lane valid of the head bundle.
- out_opcode, out, LANES*OPC_W, head opcodes; NOP_OPC where out_valid[i]=0.
- out_payload, out, LANES*PAYLOAD_W, head payload; zero where out_valid[i]=0.
- out_ready, in, 1, downstream accepts the head bundle.
- flush, in, 1, discard all held and incoming bundles.
- squash, in, LANES, clear the listed lanes of the head bundle.
- occupancy, out, 2, bundles held: 0, 1 or 2.

Behaviour:
- Reset:
  - One clock. Reset is synchronous and active-high.
  - While reset=1: state EMPTY, out_valid=0, out_opcode=NOP_OPC on all lanes, out_payload=0, occupancy=0, in_ready=0.
  - Reset mid-operation drops all contents; no partial bundle survives.
- Handshake:
  - in_fire = |in_valid & in_ready. An all-invalid bundle is never stored; bubbles compress.
  - out_fire = |out_valid & out_ready.
  - in_ready = (state != FULL) & !reset. It is combinational from registered state and never depends on out_ready, so there is no comb path from out_ready to in_ready.
- Storage and latency:
  - Entries: main (head) and skid. A bundle accepted into empty main is visible at the outputs the next cycle, i.e. 1-cycle latency.
  - States: EMPTY (occupancy 0), HALF (main holds a bundle, occupancy 1), FULL (main and skid hold bundles, occupancy 2).
- Transitions, evaluated in priority order reset > flush > squash > handshake:
  - EMPTY: in_fire -> HALF, main<=in.
  - HALF: in_fire & out_fire -> HALF, main<=in. in_fire only -> FULL, skid<=in. out_fire only -> EMPTY. Neither -> hold.
  - FULL: in_fire is impossible. out_fire -> HALF, main<=skid. Otherwise hold.
- flush=1:
  - Next state EMPTY. Outputs go to reset values except in_ready, which is 1 next cycle.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire is still a completed transfer downstream.
- squash (ignored if flush=1):
  - At the clock, the main valid bits become main_valid & ~squash.
  - Squashed lanes read NOP_OPC and zero payload from the next cycle.
  - If the result has no valid lane, the head is removed as if out_fire: FULL -> HALF with main<=skid; HALF -> EMPTY.
  - If out_fire occurs in the same cycle, the squash is ignored because the bundle has already left.
  - Squash never touches the skid entry or the incoming bundle.
- Lane ordering:
  - Lane 0 is the oldest. Lane positions never shift.
  - A bundle with valid 2'b10 is legal and passes unchanged.
- Width rules:
  - Payload is stored verbatim with no arithmetic.
  - occupancy is 2 bits; the value 3 is never produced.

Decomposition:
- Shared package pipe_pkg holds: NOP_OPC, default OPC_W, and the state encoding localparams ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2.
- One sub-module, pipe_bundle_entry, holds one bundle's storage: valid, opcode and payload registers. It has load, clear and lane-clear-mask controls and applies NOP/zero masking.
- superscalar_pipe_reg instantiates pipe_bundle_entry twice (main, skid) and contains the FSM and handshake logic.

Test Plan:
- Reset release, LANES=2: out_valid=00, out_opcode={1111,1111}, occupancy=0, in_ready=0 during reset and 1 after. Send in_valid=11, opcodes {0001,0000} -> both appear next cycle; out_fire -> occupancy=0.
- Backpressure: out_ready=0, push bundles A then B -> occupancy=2, in_ready=0. Raise out_ready -> A then B on consecutive cycles; B is never lost or duplicated.
- Streaming: out_ready=1, a new bundle every cycle for 10 cycles -> occupancy stays 1; output equals input delayed by 1 cycle, in order.
- Flush while FULL with a simultaneous in_valid=11 -> next cycle occupancy=0, out_valid=00, all opcodes NOP; the incoming bundle is dropped.
- Squash=10 on head valid=11 -> out_valid=01 next cycle, lane-1 opcode=1111, payload 0. Squash=01 on head valid=01 while FULL -> head removed, skid bundle becomes head, occupancy=1.
- Bubble: in_valid=00 with in_ready=1 -> occupancy unchanged. Squash asserted together with out_fire -> squash ignored and no extra dequeue.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the superscalar pipeline register: NOP opcode,
// default opcode width and the occupancy/state encoding.
package pipe_pkg;

  localparam int          PIPE_OPC_W   = 4;
  localparam logic [3:0]  PIPE_NOP_OPC = 4'b1111;

  localparam logic [1:0]  ST_EMPTY = 2'd0;
  localparam logic [1:0]  ST_HALF  = 2'd1;
  localparam logic [1:0]  ST_FULL  = 2'd2;

  // State code doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_HALF  = ST_HALF,
    S_FULL  = ST_FULL
  } pipe_state_e;

endpackage

// File: rtl/pipe_bundle_entry.sv
// Storage for one instruction bundle: per-lane valid, opcode and payload.
// Invalid lanes read back as NOP opcode and zero payload.
module pipe_bundle_entry
  import pipe_pkg::*;
#(
  parameter int                LANES     = 2,
  parameter int                PAYLOAD_W = 64,
  parameter int                OPC_W     = PIPE_OPC_W,
  parameter logic [OPC_W-1:0]  NOP_OPC   = OPC_W'(PIPE_NOP_OPC)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load,
  input  logic [LANES-1:0]           load_valid,
  input  logic [LANES*OPC_W-1:0]     load_opcode,
  input  logic [LANES*PAYLOAD_W-1:0] load_payload,
  input  logic [LANES-1:0]           lane_clear,
  output logic [LANES-1:0]           valid,
  output logic [LANES*OPC_W-1:0]     opcode,
  output logic [LANES*PAYLOAD_W-1:0] payload
);

  logic [LANES-1:0]           valid_reg;
  logic [LANES*OPC_W-1:0]     opcode_reg;
  logic [LANES*PAYLOAD_W-1:0] payload_reg;

  // Load wins over a lane clear so a fresh bundle is never partially erased.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid_reg <= '0;
    end else if (load) begin
      valid_reg <= load_valid;
    end else begin
      valid_reg <= valid_reg & ~lane_clear;
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      opcode_reg  <= load_opcode;
      payload_reg <= load_payload;
    end
  end

  // Reset also hides the contents combinationally, before the first edge lands.
  assign valid = valid_reg & {LANES{~reset}};

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign opcode[gi*OPC_W +: OPC_W] =
        valid[gi] ? opcode_reg[gi*OPC_W +: OPC_W] : NOP_OPC;
      assign payload[gi*PAYLOAD_W +: PAYLOAD_W] =
        valid[gi] ? payload_reg[gi*PAYLOAD_W +: PAYLOAD_W] : '0;
    end
  endgenerate

endmodule

// File: rtl/superscalar_pipe_reg.sv
// Pipeline register for a LANES-wide instruction bundle with valid/ready
// handshake, 2-entry skid buffer, global flush and per-lane head squash.
module superscalar_pipe_reg
  import pipe_pkg::*;
#(
  parameter int                LANES     = 2,
  parameter int                PAYLOAD_W = 64,
  parameter int                OPC_W     = PIPE_OPC_W,
  parameter logic [OPC_W-1:0]  NOP_OPC   = OPC_W'(PIPE_NOP_OPC)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*OPC_W-1:0]     in_opcode,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  output logic                       in_ready,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*OPC_W-1:0]     out_opcode,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic [LANES-1:0]           squash,
  output logic [1:0]                 occupancy
);

  pipe_state_e state_reg, state_next;

  logic [LANES-1:0]           main_valid;
  logic [LANES-1:0]           skid_valid;
  logic [LANES*OPC_W-1:0]     skid_opcode;
  logic [LANES*PAYLOAD_W-1:0] skid_payload;

  logic                       main_load, main_from_skid, main_clear;
  logic                       skid_load, skid_clear;
  logic [LANES-1:0]           main_lane_clear;
  logic [LANES-1:0]           main_load_valid;
  logic [LANES*OPC_W-1:0]     main_load_opcode;
  logic [LANES*PAYLOAD_W-1:0] main_load_payload;

  logic in_fire, out_fire, squash_ok, squash_empties, head_leave;
  logic [LANES-1:0] squash_mask;

  assign in_ready  = (state_reg != S_FULL) && !reset;
  assign in_fire   = (|in_valid) && in_ready;
  assign out_valid = main_valid;
  assign out_fire  = (|main_valid) && out_ready;
  assign occupancy = reset ? 2'd0 : 2'(state_reg);

  // A squash on a bundle that is leaving anyway has nothing left to act on.
  assign squash_ok      = !flush && !out_fire;
  assign squash_mask    = squash_ok ? squash : '0;
  assign squash_empties = squash_ok && (state_reg != S_EMPTY) &&
                          (|main_valid) && ((main_valid & ~squash) == '0);
  assign head_leave     = out_fire || squash_empties;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    main_load       = 1'b0;
    main_from_skid  = 1'b0;
    main_clear      = 1'b0;
    skid_load       = 1'b0;
    skid_clear      = 1'b0;
    main_lane_clear = '0;
    if (flush) begin
      state_next = S_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_reg)
        S_EMPTY: begin
          if (in_fire) begin
            main_load  = 1'b1;
            state_next = S_HALF;
          end
        end
        S_HALF: begin
          main_lane_clear = squash_mask;
          if (head_leave && in_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load  = 1'b1;
            state_next = S_FULL;
          end else if (head_leave) begin
            main_clear = 1'b1;
            state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          main_lane_clear = squash_mask;
          if (head_leave) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = S_HALF;
          end
        end
        default: begin
          state_next = S_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_load_valid   = main_from_skid ? skid_valid   : in_valid;
  assign main_load_opcode  = main_from_skid ? skid_opcode  : in_opcode;
  assign main_load_payload = main_from_skid ? skid_payload : in_payload;

  pipe_bundle_entry #(
    .LANES     (LANES),
    .PAYLOAD_W (PAYLOAD_W),
    .OPC_W     (OPC_W),
    .NOP_OPC   (NOP_OPC)
  ) u_main (
    .clock        (clock),
    .reset        (reset),
    .clear        (main_clear),
    .load         (main_load),
    .load_valid   (main_load_valid),
    .load_opcode  (main_load_opcode),
    .load_payload (main_load_payload),
    .lane_clear   (main_lane_clear),
    .valid        (main_valid),
    .opcode       (out_opcode),
    .payload      (out_payload)
  );

  pipe_bundle_entry #(
    .LANES     (LANES),
    .PAYLOAD_W (PAYLOAD_W),
    .OPC_W     (OPC_W),
    .NOP_OPC   (NOP_OPC)
  ) u_skid (
    .clock        (clock),
    .reset        (reset),
    .clear        (skid_clear),
    .load         (skid_load),
    .load_valid   (in_valid),
    .load_opcode  (in_opcode),
    .load_payload (in_payload),
    .lane_clear   ({LANES{1'b0}}),
    .valid        (skid_valid),
    .opcode       (skid_opcode),
    .payload      (skid_payload)
  );

endmodule

// File: tb/tb_superscalar_pipe_reg.sv
// Directed cycle-table bench for superscalar_pipe_reg (LANES=2): each row
// drives one cycle's inputs and checks the outputs visible in that cycle.
module tb_superscalar_pipe_reg;

  localparam int LANES = 2;
  localparam int PW    = 64;
  localparam int OW    = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [LANES-1:0]    in_valid;
  logic [LANES*OW-1:0] in_opcode;
  logic [LANES*PW-1:0] in_payload;
  logic                in_ready;
  logic [LANES-1:0]    out_valid;
  logic [LANES*OW-1:0] out_opcode;
  logic [LANES*PW-1:0] out_payload;
  logic                out_ready;
  logic                flush;
  logic [LANES-1:0]    squash;
  logic [1:0]          occupancy;

  int checks   = 0;
  int failures = 0;

  superscalar_pipe_reg #(
    .LANES(LANES), .PAYLOAD_W(PW), .OPC_W(OW), .NOP_OPC(4'b1111)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_opcode   (in_opcode),
    .in_payload  (in_payload),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_opcode  (out_opcode),
    .out_payload (out_payload),
    .out_ready   (out_ready),
    .flush       (flush),
    .squash      (squash),
    .occupancy   (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       fl;
    logic [1:0] iv;
    logic [7:0] iop;
    logic [7:0] itag;
    logic       ordy;
    logic [1:0] sq;
    logic [1:0] eov;
    logic [7:0] eop;
    logic [7:0] etag;
    logic [1:0] eocc;
    logic       eir;
  } row_t;

  row_t rows[$];

  function automatic logic [PW-1:0] mk(input logic [7:0] tag, input int lane);
    logic [31:0] low;
    low = 32'(tag) * 32'd3 + 32'(lane);
    return {tag, 8'(lane), 16'hC0DE, low};
  endfunction

  function automatic logic [LANES*PW-1:0] bundle_payload(input logic [7:0] tag,
                                                         input logic [1:0] v,
                                                         input logic all_lanes);
    logic [LANES*PW-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++)
      if (all_lanes || v[i]) p[i*PW +: PW] = mk(tag, i);
    return p;
  endfunction

  task automatic add(input logic rst, input logic fl, input logic [1:0] iv,
                     input logic [7:0] iop, input logic [7:0] itag,
                     input logic ordy, input logic [1:0] sq,
                     input logic [1:0] eov, input logic [7:0] eop,
                     input logic [7:0] etag, input logic [1:0] eocc,
                     input logic eir);
    row_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.iop = iop; r.itag = itag;
    r.ordy = ordy; r.sq = sq; r.eov = eov; r.eop = eop; r.etag = etag;
    r.eocc = eocc; r.eir = eir;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] op_cur, op_prev;
    reset = 1'b1; flush = 1'b0; in_valid = '0; in_opcode = '0;
    in_payload = '0; out_ready = 1'b0; squash = '0;

    // rst fl  iv    iop    tag    ordy sq    | eov   eop    etag   occ ir
    add(1, 0, 2'b11, 8'h10, 8'h01, 1, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 0);
    add(1, 0, 2'b11, 8'h10, 8'h01, 1, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 0);
    add(0, 0, 2'b11, 8'h10, 8'h01, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b11, 8'h10, 8'h01, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    // backpressure: A, B stored, C refused
    add(0, 0, 2'b11, 8'h32, 8'h0A, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b11, 8'h54, 8'h0B, 0, 2'b00,  2'b11, 8'h32, 8'h0A, 1, 1);
    add(0, 0, 2'b11, 8'h76, 8'h0C, 0, 2'b00,  2'b11, 8'h32, 8'h0A, 2, 0);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b11, 8'h32, 8'h0A, 2, 0);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b11, 8'h54, 8'h0B, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    // streaming: output is input delayed one cycle
    op_prev = 8'hFF;
    for (int s = 0; s < 10; s++) begin
      op_cur = {4'(s + 1), 4'(s)};
      if (s == 0) add(0, 0, 2'b11, op_cur, 8'h20, 1, 2'b00, 2'b00, 8'hFF, 8'h00, 0, 1);
      else        add(0, 0, 2'b11, op_cur, 8'(8'h20 + s), 1, 2'b00,
                      2'b11, op_prev, 8'(8'h20 + s - 1), 1, 1);
      op_prev = op_cur;
    end
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b11, 8'hA9, 8'h29, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    // flush while FULL, then flush in HALF with a same-cycle in_fire
    add(0, 0, 2'b11, 8'h98, 8'h40, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b11, 8'hBA, 8'h41, 0, 2'b00,  2'b11, 8'h98, 8'h40, 1, 1);
    add(0, 1, 2'b11, 8'hDC, 8'h42, 0, 2'b00,  2'b11, 8'h98, 8'h40, 2, 0);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b11, 8'h21, 8'h43, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 1, 2'b11, 8'h43, 8'h44, 0, 2'b00,  2'b11, 8'h21, 8'h43, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    // squash: partial lane-1, then full head while FULL, then with out_fire
    add(0, 0, 2'b11, 8'h65, 8'h50, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b11, 8'h87, 8'h51, 0, 2'b10,  2'b11, 8'h65, 8'h50, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b01,  2'b01, 8'hF5, 8'h50, 2, 0);
    add(0, 0, 2'b11, 8'hA9, 8'h52, 0, 2'b00,  2'b11, 8'h87, 8'h51, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b11,  2'b11, 8'h87, 8'h51, 2, 0);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b11, 8'hA9, 8'h52, 1, 1);
    // bubble leaves occupancy alone; lane-1-only bundle passes unchanged
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b11, 8'hA9, 8'h52, 1, 1);
    add(0, 0, 2'b10, 8'hCB, 8'h53, 1, 2'b00,  2'b11, 8'hA9, 8'h52, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b10, 8'hCF, 8'h53, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 1, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    // reset mid-operation while FULL
    add(0, 0, 2'b11, 8'h10, 8'h60, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b11, 8'h32, 8'h61, 0, 2'b00,  2'b11, 8'h10, 8'h60, 1, 1);
    add(1, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 0);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    // squash of every valid lane in HALF empties the register
    add(0, 0, 2'b11, 8'h54, 8'h70, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b11,  2'b11, 8'h54, 8'h70, 1, 1);
    add(0, 0, 2'b00, 8'h00, 8'h00, 0, 2'b00,  2'b00, 8'hFF, 8'h00, 0, 1);

    foreach (rows[k]) begin
      @(negedge clock);
      reset      = rows[k].rst;
      flush      = rows[k].fl;
      in_valid   = rows[k].iv;
      in_opcode  = rows[k].iop;
      in_payload = bundle_payload(rows[k].itag, 2'b11, 1'b1);
      out_ready  = rows[k].ordy;
      squash     = rows[k].sq;
      #1;
      chk($sformatf("row%0d out_valid", k), 128'(out_valid), 128'(rows[k].eov));
      chk($sformatf("row%0d out_opcode", k), 128'(out_opcode), 128'(rows[k].eop));
      chk($sformatf("row%0d out_payload", k), out_payload,
          bundle_payload(rows[k].etag, rows[k].eov, 1'b0));
      chk($sformatf("row%0d occupancy", k), 128'(occupancy), 128'(rows[k].eocc));
      chk($sformatf("row%0d in_ready", k), 128'(in_ready), 128'(rows[k].eir));
      $display("row %0d rst=%b fl=%b iv=%b ordy=%b sq=%b -> ov=%b op=%h occ=%0d ir=%b",
               k, reset, flush, in_valid, out_ready, squash,
               out_valid, out_opcode, occupancy, in_ready);
    end

    // in_ready must not react to out_ready within the same cycle
    @(negedge clock);
    in_valid = 2'b01; in_opcode = 8'hF3; in_payload = bundle_payload(8'h80, 2'b11, 1'b1);
    out_ready = 1'b0; squash = '0; flush = 1'b0; reset = 1'b0;
    @(negedge clock);
    in_valid = 2'b00; out_ready = 1'b0; #1;
    chk("seq occupancy_half", 128'(occupancy), 128'(2'd1));
    chk("seq in_ready_ordy0", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1; #1;
    chk("seq in_ready_ordy1", 128'(in_ready), 128'(1'b1));
    chk("seq lane0_only_opcode", 128'(out_opcode), 128'(8'hF3));
    $display("seq comb-path ir=%b occ=%0d ov=%b", in_ready, occupancy, out_valid);
    @(negedge clock);
    out_ready = 1'b0; #1;
    chk("seq drained_occ", 128'(occupancy), 128'(2'd0));
    chk("seq drained_valid", 128'(out_valid), 128'(2'b00));
    $display("seq drain occ=%0d ov=%b", occupancy, out_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
